br_resolve: RTL and testbench

Branch resolution unit at the EX/ID boundary. It is the consumer end of the branch-prediction path. It compares the prediction carried with the delay-slot instruction in ID (`bp_id_bus`) against the real outcome of the branch in EX. It generates the one-cycle redirect/training pulse on `br_bus` plus `delayslot_pc`, which go back to the predictor and fetch. When the delay slot has not yet reached ID, the branch outcome is held until it arrives. Performance counters track resolved branches and redirects.

---
 rtl/br_resolve_pkg.sv | 9 +
 rtl/br_perf_cnt.sv | 14 +
 rtl/br_resolve.sv | 70 +++++++
 tb/tb_br_resolve.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/br_resolve_pkg.sv
// br_resolve_pkg: shared widths, FSM encodings and the redirect decision for branch resolution
package br_resolve_pkg;
  localparam int BR_WD = 33;
  typedef enum logic {BRR_IDLE = 1'b0, BRR_WAIT_DS = 1'b1} brr_state_t;
  function automatic logic [BR_WD-1:0] br_decide(input logic t, input logic [31:0] x,
                                                 input logic [BR_WD-1:0] bp, input logic [31:0] pc);
    return {t ? (!bp[BR_WD-1] || x != bp[31:0]) : bp[BR_WD-1], t ? x : pc + 32'd4};
  endfunction
endpackage

// File: rtl/br_perf_cnt.sv
// br_perf_cnt: wrapping event counter with synchronous clear and increment enable
module br_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt
);
  // count enabled events, wrapping naturally at 2^W
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/br_resolve.sv
// br_resolve: compares the delay-slot prediction with the EX branch outcome and issues redirects
module br_resolve
  import br_resolve_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  input  logic             id_valid,
  input  logic [31:0]      id_pc,
  input  logic [BR_WD-1:0] bp_id_bus,
  output logic [BR_WD-1:0] br_bus,
  output logic [31:0]      delayslot_pc,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mis_cnt
);
  brr_state_t state, state_nx;
  logic hold_t, latch, res, res_t, br_inc, redirect;
  logic [31:0] hold_x, res_x;
  logic [BR_WD-1:0] dec;
  // pick the resolution source; a live br_e squashes everything younger than the delay slot
  always_comb begin
    state_nx = state;
    latch = 1'b0;
    res = 1'b0;
    res_t = ex_taken;
    res_x = ex_target;
    br_inc = 1'b0;
    if (!br_bus[BR_WD-1] && !stall) begin
      if (state == BRR_WAIT_DS) begin
        res = id_valid;
        res_t = hold_t;
        res_x = hold_x;
        br_inc = id_valid;
        state_nx = id_valid ? BRR_IDLE : BRR_WAIT_DS;
      end else if (ex_valid && ex_is_branch) begin
        res = id_valid;
        br_inc = id_valid;
        latch = !id_valid;
        state_nx = id_valid ? BRR_IDLE : BRR_WAIT_DS;
      end else if (ex_valid && id_valid && bp_id_bus[BR_WD-1]) begin
        res = 1'b1;
        res_t = 1'b0;
      end
    end
  end
  assign dec = br_decide(res_t, res_x, bp_id_bus, id_pc);
  assign redirect = res && dec[BR_WD-1];
  // state, held outcome and the one-cycle redirect pulse
  always_ff @(posedge clk)
    if (rst) begin
      state <= BRR_IDLE;
      hold_t <= 1'b0;
      hold_x <= '0;
      br_bus <= '0;
      delayslot_pc <= '0;
    end else begin
      state <= state_nx;
      if (latch) {hold_t, hold_x} <= {ex_taken, ex_target};
      br_bus <= redirect ? dec : {1'b0, br_bus[31:0]};
      if (redirect) delayslot_pc <= id_pc;
    end
  br_perf_cnt #(.W(CNT_W)) u_br_cnt (.clk(clk), .rst(rst), .en(br_inc), .cnt(br_cnt));
  br_perf_cnt #(.W(CNT_W)) u_mis_cnt (.clk(clk), .rst(rst), .en(redirect), .cnt(mis_cnt));
endmodule

// File: tb/tb_br_resolve.sv
// tb_br_resolve: directed plus randomized checking of br_resolve against a behavioural model
module tb_br_resolve;
  import br_resolve_pkg::*;
  logic clk = 1'b0, rst, stall, ex_valid, ex_is_branch, ex_taken, id_valid;
  logic [31:0] ex_target, id_pc, delayslot_pc, br_cnt, mis_cnt;
  logic [BR_WD-1:0] bp_id_bus, br_bus;
  int checks = 0, errors = 0;
  logic exp_e;
  logic [31:0] exp_tgt, exp_ds, exp_br, exp_mis, saved;
  logic [32:0] pend[$];

  br_resolve #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_taken(ex_taken), .ex_target(ex_target), .id_valid(id_valid), .id_pc(id_pc),
    .bp_id_bus(bp_id_bus), .br_bus(br_bus), .delayslot_pc(delayslot_pc),
    .br_cnt(br_cnt), .mis_cnt(mis_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic redirect_to(input logic [31:0] dst);
    exp_e = 1'b1;
    exp_tgt = dst;
    exp_ds = id_pc;
    exp_mis++;
  endtask

  task automatic resolve(input logic t, input logic [31:0] x);
    logic p;
    p = bp_id_bus[32];
    exp_br++;
    if (t && p && x == bp_id_bus[31:0]) return;
    else if (t) redirect_to(x);
    else if (p) redirect_to(id_pc + 32'd4);
  endtask

  task automatic model_edge();
    logic [32:0] h;
    logic squash;
    squash = exp_e;
    exp_e = 1'b0;
    if (rst) begin
      exp_tgt = 0; exp_ds = 0; exp_br = 0; exp_mis = 0;
      pend.delete();
    end else if (!squash && !stall) begin
      if (pend.size() != 0) begin
        if (id_valid) begin
          h = pend.pop_front();
          resolve(h[32], h[31:0]);
        end
      end else if (ex_valid && ex_is_branch) begin
        if (id_valid) resolve(ex_taken, ex_target);
        else pend.push_back({ex_taken, ex_target});
      end else if (ex_valid && id_valid && bp_id_bus[32]) redirect_to(id_pc + 32'd4);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("br_e", {31'd0, br_bus[32]}, {31'd0, exp_e});
    if (exp_e) begin
      chk("br_target", br_bus[31:0], exp_tgt);
      chk("delayslot_pc", delayslot_pc, exp_ds);
    end
    chk("br_cnt", br_cnt, exp_br);
    chk("mis_cnt", mis_cnt, exp_mis);
  endtask

  task automatic drive(input logic ev, input logic br, input logic t, input logic [31:0] x,
                       input logic iv, input logic [31:0] pc, input logic p, input logic [31:0] pt);
    ex_valid = ev; ex_is_branch = br; ex_taken = t; ex_target = x;
    id_valid = iv; id_pc = pc; bp_id_bus = {p, pt};
  endtask

  task automatic idle();
    drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    tick();
  endtask

  initial begin
    exp_e = 0; exp_tgt = 0; exp_ds = 0; exp_br = 0; exp_mis = 0;
    rst = 1; stall = 0;
    drive(1, 1, 1, 32'h1234, 1, 32'h10, 1, 32'h99);
    tick();
    tick();
    chk("reset_br_bus_lo", br_bus[31:0], 32'h0);
    chk("reset_ds", delayslot_pc, 32'h0);
    rst = 0;
    // correct prediction
    drive(1, 1, 1, 32'hBFC00100, 1, 32'hBFC00014, 1, 32'hBFC00100);
    tick();
    chk("correct_br_e", {31'd0, br_bus[32]}, 32'd0);
    chk("correct_br_cnt", br_cnt, 32'd1);
    chk("correct_mis_cnt", mis_cnt, 32'd0);
    // predicted not-taken, branch taken
    drive(1, 1, 1, 32'hBFC00100, 1, 32'hBFC00014, 0, 32'h0);
    tick();
    chk("nt_br_bus_e", {31'd0, br_bus[32]}, 32'd1);
    chk("nt_target", br_bus[31:0], 32'hBFC00100);
    chk("nt_ds", delayslot_pc, 32'hBFC00014);
    chk("nt_mis_cnt", mis_cnt, 32'd1);
    idle();
    // over-prediction
    drive(1, 1, 0, 32'h0, 1, 32'h80000010, 1, 32'h80000040);
    tick();
    chk("over_target", br_bus[31:0], 32'h80000014);
    idle();
    chk("over_one_cycle", {31'd0, br_bus[32]}, 32'd0);
    // delay slot late
    drive(1, 1, 1, 32'h1000, 0, 32'h0, 0, 32'h0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, 32'h5555, 0, 32'h0, 1, 32'h7);
      tick();
      chk("late_wait_no_e", {31'd0, br_bus[32]}, 32'd0);
    end
    drive(1, 1, 0, 32'h2222, 1, 32'h0FFC, 0, 32'h0);
    tick();
    chk("late_target", br_bus[31:0], 32'h1000);
    idle();
    // reset during wait
    drive(1, 1, 1, 32'h1000, 0, 32'h0, 0, 32'h0);
    tick();
    rst = 1;
    idle();
    rst = 0;
    drive(0, 0, 0, 32'h0, 1, 32'h0FFC, 0, 32'h0);
    tick();
    chk("rst_wait_no_e", {31'd0, br_bus[32]}, 32'd0);
    chk("rst_wait_br_cnt", br_cnt, 32'd0);
    chk("rst_wait_mis_cnt", mis_cnt, 32'd0);
    // false hit with address wrap
    saved = br_cnt;
    drive(1, 0, 0, 32'h0, 1, 32'hFFFFFFFC, 1, 32'h40);
    tick();
    chk("fh_target", br_bus[31:0], 32'h0);
    chk("fh_br_cnt", br_cnt, saved);
    idle();
    // squash of the instruction following a redirect
    drive(1, 1, 1, 32'h3000, 1, 32'h2004, 0, 32'h0);
    tick();
    saved = br_cnt;
    drive(1, 1, 1, 32'h4000, 1, 32'h3000, 0, 32'h0);
    tick();
    chk("squash_no_e", {31'd0, br_bus[32]}, 32'd0);
    chk("squash_br_cnt", br_cnt, saved);
    // stall holds the resolution
    stall = 1;
    drive(1, 1, 1, 32'h5000, 1, 32'h4004, 0, 32'h0);
    tick();
    tick();
    chk("stall_no_e", {31'd0, br_bus[32]}, 32'd0);
    stall = 0;
    tick();
    chk("stall_release_target", br_bus[31:0], 32'h5000);
    idle();
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tg;
      tg = 32'h100 << $urandom_range(0, 3);
      rst = ($urandom_range(0, 99) == 0);
      stall = ($urandom_range(0, 4) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 1'($urandom),
            ($urandom_range(0, 7) == 0) ? $urandom : tg, $urandom_range(0, 2) != 0,
            ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC : {$urandom_range(0, 255), 2'b00},
            1'($urandom), 32'h100 << $urandom_range(0, 3));
      tick();
    end
    rst = 0;
    stall = 0;
    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
